// File: rtl/ttt_pkg.sv
// Shared codes and state encoding for the tic-tac-toe turn controller.
package ttt_pkg;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] P1    = 2'b01;
   localparam logic [1:0] P2    = 2'b10;
   localparam logic [1:0] DRAW  = 2'b11;

   localparam logic [3:0] MAX_MOVES = 4'd9;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_MOVE = 2'b01,
      CHECK     = 2'b10,
      OVER      = 2'b11
   } state_e;

endpackage

// File: rtl/ttt_turn_controller_bcd_turn_timer.sv
// Per-turn countdown: prescaler producing one-second ticks and a two-digit BCD down-counter.
module bcd_turn_timer #(
   parameter int unsigned TICK_DIV     = 50_000_000,
   parameter int unsigned TURN_SECONDS = 30
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic       i_run,
   output logic [3:0] o_ten_digit,
   output logic [3:0] o_unit_digit,
   output logic       o_zero
);

   localparam int unsigned    PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0]     TEN_INIT   = 4'(TURN_SECONDS / 10);
   localparam logic [3:0]     UNIT_INIT  = 4'(TURN_SECONDS % 10);

   logic [PW-1:0] r_presc;
   logic [3:0]    r_ten;
   logic [3:0]    r_unit;
   logic          w_zero;

   assign w_zero = (r_ten == 4'd0) && (r_unit == 4'd0);

   // Load wins over run so a move on the final tick reloads instead of expiring.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_presc <= '0;
         r_ten   <= TEN_INIT;
         r_unit  <= UNIT_INIT;
      end else if (i_run) begin
         if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            if (!w_zero) begin
               if (r_unit == 4'd0) begin
                  r_unit <= 4'd9;
                  r_ten  <= r_ten - 4'd1;
               end else begin
                  r_unit <= r_unit - 4'd1;
               end
            end
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   assign o_ten_digit  = r_ten;
   assign o_unit_digit = r_unit;
   assign o_zero       = w_zero;

endmodule

// File: rtl/ttt_turn_controller.sv
// Game sequencer: owns board, turn flag and turn timer; samples the win detector after
// each move or timeout and latches the final result.
module ttt_turn_controller #(
   parameter int unsigned TICK_DIV     = 50_000_000,
   parameter int unsigned TURN_SECONDS = 30,
   parameter int unsigned CHECK_WAIT   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_valid,
   input  logic [3:0] move_pos,
   input  logic [1:0] gameend_i,
   output logic [1:0] b0,
   output logic [1:0] b1,
   output logic [1:0] b2,
   output logic [1:0] b3,
   output logic [1:0] b4,
   output logic [1:0] b5,
   output logic [1:0] b6,
   output logic [1:0] b7,
   output logic [1:0] b8,
   output logic       whos_turn,
   output logic [3:0] ten_digit,
   output logic [3:0] unit_digit,
   output logic       move_accept,
   output logic       move_reject,
   output logic [1:0] result,
   output logic [1:0] state_o
);

   import ttt_pkg::*;

   state_e          r_state, w_state_nx;
   logic [8:0][1:0] r_board, w_board_nx;
   logic            r_turn, w_turn_nx;
   logic [3:0]      r_move_cnt, w_move_cnt_nx;
   logic [1:0]      r_result, w_result_nx;
   logic            r_accept, w_accept_nx;
   logic            r_reject, w_reject_nx;
   logic [1:0]      r_chk_cnt, w_chk_cnt_nx;
   logic            w_load, w_run, w_zero;
   logic [1:0]      w_cell;
   logic            w_legal;

   bcd_turn_timer #(
      .TICK_DIV     (TICK_DIV),
      .TURN_SECONDS (TURN_SECONDS)
   ) u_timer (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_load       (w_load),
      .i_run        (w_run),
      .o_ten_digit  (ten_digit),
      .o_unit_digit (unit_digit),
      .o_zero       (w_zero)
   );

   always_comb begin
      w_cell = EMPTY;
      for (int i = 0; i < 9; i++) begin
         if (move_pos == 4'(i)) w_cell = r_board[i];
      end
      w_legal = (move_pos <= 4'd8) && (w_cell == EMPTY);
   end

   always_comb begin
      w_state_nx    = r_state;
      w_board_nx    = r_board;
      w_turn_nx     = r_turn;
      w_move_cnt_nx = r_move_cnt;
      w_result_nx   = r_result;
      w_accept_nx   = 1'b0;
      w_reject_nx   = 1'b0;
      w_chk_cnt_nx  = r_chk_cnt;
      w_load        = 1'b0;
      w_run         = 1'b0;
      unique case (r_state)
         IDLE, OVER: begin
            if (start) begin
               w_state_nx    = WAIT_MOVE;
               w_board_nx    = '0;
               w_turn_nx     = 1'b0;
               w_move_cnt_nx = 4'd0;
               w_result_nx   = EMPTY;
               w_load        = 1'b1;
            end
         end
         WAIT_MOVE: begin
            w_run = 1'b1;
            if (move_valid && w_legal) begin
               for (int i = 0; i < 9; i++) begin
                  if (move_pos == 4'(i)) w_board_nx[i] = r_turn ? P2 : P1;
               end
               w_turn_nx     = ~r_turn;
               w_move_cnt_nx = (r_move_cnt == MAX_MOVES) ? MAX_MOVES : r_move_cnt + 4'd1;
               w_load        = 1'b1;
               w_accept_nx   = 1'b1;
               w_chk_cnt_nx  = 2'd0;
               w_state_nx    = CHECK;
            end else begin
               w_reject_nx = move_valid;
               // Timer at 00: turn is not toggled, so the detector sees the timed-out player.
               if (w_zero) begin
                  w_chk_cnt_nx = 2'd0;
                  w_state_nx   = CHECK;
               end
            end
         end
         CHECK: begin
            if (r_chk_cnt == 2'(CHECK_WAIT)) begin
               if (gameend_i != EMPTY) begin
                  w_result_nx = gameend_i;
                  w_state_nx  = OVER;
               end else if (r_move_cnt == MAX_MOVES) begin
                  w_result_nx = DRAW;
                  w_state_nx  = OVER;
               end else begin
                  w_state_nx = WAIT_MOVE;
               end
            end else begin
               w_chk_cnt_nx = r_chk_cnt + 2'd1;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_board    <= '0;
         r_turn     <= 1'b0;
         r_move_cnt <= 4'd0;
         r_result   <= EMPTY;
         r_accept   <= 1'b0;
         r_reject   <= 1'b0;
         r_chk_cnt  <= 2'd0;
      end else begin
         r_state    <= w_state_nx;
         r_board    <= w_board_nx;
         r_turn     <= w_turn_nx;
         r_move_cnt <= w_move_cnt_nx;
         r_result   <= w_result_nx;
         r_accept   <= w_accept_nx;
         r_reject   <= w_reject_nx;
         r_chk_cnt  <= w_chk_cnt_nx;
      end
   end

   assign b0          = r_board[0];
   assign b1          = r_board[1];
   assign b2          = r_board[2];
   assign b3          = r_board[3];
   assign b4          = r_board[4];
   assign b5          = r_board[5];
   assign b6          = r_board[6];
   assign b7          = r_board[7];
   assign b8          = r_board[8];
   assign whos_turn   = r_turn;
   assign move_accept = r_accept;
   assign move_reject = r_reject;
   assign result      = r_result;
   assign state_o     = r_state;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Scoreboard bench: stimulus queues expected accept/reject/game-over events, a monitor checks them.
module tb_ttt_turn_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic       move_valid;
   logic [3:0] move_pos;
   logic [1:0] gameend;
   logic [1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
   logic       whos_turn;
   logic [3:0] ten_digit, unit_digit;
   logic       move_accept, move_reject;
   logic [1:0] result;
   logic [1:0] state_o;
   logic [1:0] brd [9];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         kind;  // 0 accept, 1 reject, 2 game over
      int         pos;
      logic [1:0] mark;
      logic       turn;
      logic [1:0] res;
   } exp_t;

   exp_t sbq[$];

   int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

   ttt_turn_controller #(
      .TICK_DIV     (4),
      .TURN_SECONDS (30),
      .CHECK_WAIT   (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .move_valid  (move_valid),
      .move_pos    (move_pos),
      .gameend_i   (gameend),
      .b0          (b0),
      .b1          (b1),
      .b2          (b2),
      .b3          (b3),
      .b4          (b4),
      .b5          (b5),
      .b6          (b6),
      .b7          (b7),
      .b8          (b8),
      .whos_turn   (whos_turn),
      .ten_digit   (ten_digit),
      .unit_digit  (unit_digit),
      .move_accept (move_accept),
      .move_reject (move_reject),
      .result      (result),
      .state_o     (state_o)
   );

   assign brd[0] = b0;
   assign brd[1] = b1;
   assign brd[2] = b2;
   assign brd[3] = b3;
   assign brd[4] = b4;
   assign brd[5] = b5;
   assign brd[6] = b6;
   assign brd[7] = b7;
   assign brd[8] = b8;

   // Stand-in game-end detector: three in a row, else timeout blames the player to move.
   always_comb begin
      gameend = 2'b00;
      for (int l = 0; l < 8; l++) begin
         if (brd[lines[l][0]] != 2'b00 && brd[lines[l][0]] == brd[lines[l][1]] &&
             brd[lines[l][0]] == brd[lines[l][2]])
            gameend = brd[lines[l][0]];
      end
      if (gameend == 2'b00 && state_o == 2'b10 && ten_digit == 4'd0 && unit_digit == 4'd0)
         gameend = whos_turn ? 2'b10 : 2'b01;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per observed DUT event.
   initial begin
      logic [1:0] prev;
      exp_t       e;
      prev = 2'b00;
      forever begin
         @(negedge clk);
         if (move_accept || move_reject) begin
            if (sbq.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("event_kind", move_accept ? 0 : 1, e.kind);
               if (e.kind == 0) begin
                  chk("accept_cell", int'(brd[e.pos]), int'(e.mark));
                  chk("accept_turn", int'(whos_turn), int'(e.turn));
               end
            end
         end
         if (!rst && state_o == 2'b11 && prev != 2'b11) begin
            if (sbq.size() == 0) begin
               chk("unexpected_over", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("over_kind", 2, e.kind);
               chk("over_result", int'(result), int'(e.res));
            end
         end
         prev = state_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] s, input string name);
      int n = 0;
      while (state_o != s && n < 50) begin
         tick();
         n++;
      end
      chk(name, int'(state_o), int'(s));
   endtask

   task automatic push_over(input logic [1:0] r);
      exp_t e;
      e.kind = 2; e.pos = 0; e.mark = 2'b00; e.turn = 1'b0; e.res = r;
      sbq.push_back(e);
   endtask

   task automatic do_move(input int p, input bit legal, input logic [1:0] mark,
                          input logic turn_after);
      exp_t e;
      e.kind = legal ? 0 : 1; e.pos = p; e.mark = mark; e.turn = turn_after; e.res = 2'b00;
      sbq.push_back(e);
      move_valid = 1'b1;
      move_pos   = 4'(p);
      tick();
      move_valid = 1'b0;
   endtask

   task automatic play(input int s[$], input logic [1:0] res);
      for (int i = 0; i < s.size(); i++) begin
         do_move(s[i], 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0));
         if (i == s.size() - 1) begin
            push_over(res);
            wait_state(2'b11, "game_over_state");
         end else begin
            wait_state(2'b01, "back_to_wait");
         end
      end
   endtask

   task automatic check_clear(input logic [1:0] st, input string tag);
      logic [1:0] any;
      any = 2'b00;
      for (int i = 0; i < 9; i++) any |= brd[i];
      chk({tag, "_board"}, int'(any), 0);
      chk({tag, "_state"}, int'(state_o), int'(st));
      chk({tag, "_digits"}, int'({ten_digit, unit_digit}), 'h30);
      chk({tag, "_result"}, int'(result), 0);
      chk({tag, "_turn"}, int'(whos_turn), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v;
      rst        = 1'b1;
      start      = 1'b0;
      move_valid = 1'b0;
      move_pos   = 4'd0;
      tick();
      tick();
      check_clear(2'b00, "reset");
      chk("reset_pulses", int'({move_accept, move_reject}), 0);
      rst = 1'b0;

      // Player 1 wins down the left column.
      pulse_start();
      wait_state(2'b01, "start_wait");
      play('{0, 1, 3, 2, 6}, 2'b01);

      // Restart from OVER clears everything, then a full-board draw.
      pulse_start();
      check_clear(2'b01, "restart");
      play('{0, 1, 2, 4, 3, 5, 7, 6, 8}, 2'b11);

      // Occupied cell and out-of-range index are both rejected.
      pulse_start();
      wait_state(2'b01, "illegal_wait");
      do_move(4, 1'b1, 2'b01, 1'b1);
      wait_state(2'b01, "illegal_back");
      do_move(4, 1'b0, 2'b00, 1'b1);
      do_move(12, 1'b0, 2'b00, 1'b1);
      tick();
      chk("illegal_b4", int'(b4), 1);
      chk("illegal_turn", int'(whos_turn), 1);
      chk("illegal_state", int'(state_o), 1);

      // Reset in the middle of a game.
      rst = 1'b1;
      tick();
      check_clear(2'b00, "midreset");
      rst = 1'b0;

      // Timeout: no moves; the digits count 30 down to 00 at one step per 4 cycles.
      push_over(2'b01);
      pulse_start();
      for (int k = 0; k <= 120; k++) begin
         v = 30 - k / 4;
         chk("timeout_digits", int'({ten_digit, unit_digit}), ((v / 10) << 4) | (v % 10));
         if (k < 120) tick();
      end
      wait_state(2'b10, "timeout_check");
      chk("timeout_turn", int'(whos_turn), 0);
      wait_state(2'b11, "timeout_over");

      // Move on the exact cycle the timer would reach 00.
      pulse_start();
      for (int k = 0; k < 119; k++) tick();
      chk("simul_pre_digits", int'({ten_digit, unit_digit}), 'h01);
      do_move(0, 1'b1, 2'b01, 1'b1);
      chk("simul_reload", int'({ten_digit, unit_digit}), 'h30);
      wait_state(2'b01, "simul_no_timeout");
      chk("simul_digits_after", int'({ten_digit, unit_digit}), 'h30);
      chk("simul_result", int'(result), 0);

      for (int k = 0; k < 4; k++) tick();
      chk("queue_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
